// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_t;

  localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ready;
  logic                  if_stall;
  logic                  flush_if;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_ready;
  logic                  dm_stall;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, flush_if, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, flush_if, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory between fetch and data ports; data wins,
// each access is sequenced by a latency down-counter and returns registered data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT out of range 1..15");
  end

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              discard_q, discard_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic   idle;
  logic   dm_acc;
  logic   if_acc;
  logic   cnt_done;
  grant_t gnt;

  // Outputs are forced low while reset is asserted, even with requests held.
  assign idle     = rst_n && (state_q == ARB_IDLE);
  assign dm_acc   = idle && bus.dm_req && !dm_ready_q;
  assign if_acc   = idle && bus.if_req && !if_ready_q && !bus.flush_if && !dm_acc;
  assign gnt      = dm_acc ? GNT_DM : GNT_IF;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    bus.mem_en    = dm_acc || if_acc;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (bus.mem_en) begin
      case (gnt)
        GNT_DM: begin
          bus.mem_we    = bus.dm_we;
          bus.mem_addr  = bus.dm_addr;
          bus.mem_wdata = bus.dm_wdata;
          bus.mem_be    = bus.dm_be;
        end
        default: bus.mem_addr = bus.if_addr;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        discard_d = 1'b0;
        if (dm_acc) begin
          if (bus.dm_we) begin
            // Stores complete without a wait state, leaving the port free next cycle.
            cnt_d      = '0;
            dm_ready_d = 1'b1;
          end else begin
            cnt_d   = LAT_M1;
            state_d = ARB_BUSY_D;
          end
        end else if (if_acc) begin
          cnt_d   = LAT_M1;
          state_d = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I: begin
        if (cnt_done) begin
          state_d   = ARB_IDLE;
          discard_d = 1'b0;
          if (!(discard_q || bus.flush_if)) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (bus.flush_if) discard_d = 1'b1;
        end
      end
      ARB_BUSY_D: begin
        if (cnt_done) begin
          state_d    = ARB_IDLE;
          dm_ready_d = 1'b1;
          dm_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_ready = if_ready_q;
  assign bus.dm_ready = dm_ready_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.if_stall = rst_n && bus.if_req && !if_ready_q;
  assign bus.dm_stall = rst_n && bus.dm_req && !dm_ready_q;

  logic [BE_W-1:0] be_unused;
  assign be_unused = bus.mem_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and a two-stage memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_en = 0;
  logic [31:0] p1 = '0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  // Read data appears two cycles after the mem_en cycle.
  always @(posedge clk) begin
    p1            <= (bus.mem_en && !bus.mem_we) ? memval(bus.mem_addr) : 32'h0;
    bus.mem_rdata <= p1;
    if (bus.mem_en) n_en <= n_en + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_ctl"}, 32'(|{bus.if_ready, bus.dm_ready, bus.if_stall, bus.dm_stall,
                               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}), 32'h0);
    check({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    check({tag, "_dm_rdata"}, bus.dm_rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int last;
    int n0;
    int cnt;
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.flush_if = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000;
    bus.dm_wdata = '0; bus.dm_be = '0;
    #1;
    outs_zero("reset");
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
    nxt();

    // 1. fetch only
    bus.if_req = 1'b1; bus.if_addr = 32'h100; #1;
    check("t1_en_T", bus.mem_en, 1); check("t1_addr_T", bus.mem_addr, 32'h100);
    check("t1_stall_T", bus.if_stall, 1);
    nxt(); check("t1_en_T1", bus.mem_en, 0); check("t1_stall_T1", bus.if_stall, 1);
    nxt(); check("t1_rdy_T2", bus.if_ready, 0); check("t1_stall_T2", bus.if_stall, 1);
    nxt(); check("t1_rdy_T3", bus.if_ready, 1); check("t1_data", bus.if_rdata, 32'h0050_0093);
    check("t1_stall_T3", bus.if_stall, 0); check("t1_noreacc", bus.mem_en, 0);
    bus.if_req = 1'b0;
    nxt(); check("t1_rdy_T4", bus.if_ready, 0);

    // 2. collision: data first
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000; #1;
    check("t2_addr_T", bus.mem_addr, 32'h2000); check("t2_we_T", bus.mem_we, 0);
    nxt(); check("t2_en_T1", bus.mem_en, 0);
    nxt(); check("t2_dmrdy_T2", bus.dm_ready, 0);
    nxt(); check("t2_dmrdy_T3", bus.dm_ready, 1); check("t2_dmdata", bus.dm_rdata, memval(32'h2000));
    check("t2_en_T3", bus.mem_en, 1); check("t2_addr_T3", bus.mem_addr, 32'h104);
    bus.dm_req = 1'b0;
    nxt(); nxt(); check("t2_ifrdy_T5", bus.if_ready, 0);
    nxt(); check("t2_ifrdy_T6", bus.if_ready, 1); check("t2_ifdata", bus.if_rdata, memval(32'h104));
    bus.if_req = 1'b0;
    nxt();

    // 3. store with a pending fetch
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2004;
    bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
    bus.if_req = 1'b1; bus.if_addr = 32'h108; #1;
    check("t3_en", bus.mem_en, 1); check("t3_we", bus.mem_we, 1);
    check("t3_be", 32'(bus.mem_be), 32'h3); check("t3_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("t3_addr", bus.mem_addr, 32'h2004);
    nxt(); check("t3_dmrdy", bus.dm_ready, 1); check("t3_dmhold", bus.dm_rdata, memval(32'h2000));
    check("t3_fetch_en", bus.mem_en, 1); check("t3_fetch_addr", bus.mem_addr, 32'h108);
    check("t3_fetch_we", bus.mem_we, 0); check("t3_fetch_be", 32'(bus.mem_be), 32'h0);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    nxt(); check("t3_dmrdy_off", bus.dm_ready, 0);
    nxt(); nxt(); check("t3_ifrdy", bus.if_ready, 1); check("t3_ifdata", bus.if_rdata, memval(32'h108));
    bus.if_req = 1'b0;
    nxt();

    // 4. flush mid-fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h200; #1;
    check("t4_addr_T", bus.mem_addr, 32'h200);
    nxt(); bus.flush_if = 1'b1; bus.if_addr = 32'h300; #1;
    check("t4_en_T1", bus.mem_en, 0);
    nxt(); bus.flush_if = 1'b0; #1; check("t4_en_T2", bus.mem_en, 0);
    nxt(); check("t4_noready", bus.if_ready, 0); check("t4_keep", bus.if_rdata, memval(32'h108));
    check("t4_en_T3", bus.mem_en, 1); check("t4_addr_T3", bus.mem_addr, 32'h300);
    nxt(); nxt(); nxt();
    check("t4_rdy_T6", bus.if_ready, 1); check("t4_data", bus.if_rdata, memval(32'h300));
    bus.if_req = 1'b0;
    nxt();

    // 5. reset in the middle of a load
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2008; #1;
    check("t5_en_T", bus.mem_en, 1);
    nxt(); rst_n = 1'b0; #1;
    outs_zero("t5_rst");
    bus.dm_req = 1'b0;
    nxt(); nxt(); rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus.dm_ready || bus.mem_en) cnt++;
      nxt();
    end
    check("t5_no_ready", 32'(cnt), 32'h0);
    bus.dm_req = 1'b1; bus.dm_addr = 32'h200C; #1;
    check("t5_reload_en", bus.mem_en, 1);
    nxt(); nxt(); nxt();
    check("t5_reload_rdy", bus.dm_ready, 1); check("t5_reload_data", bus.dm_rdata, memval(32'h200C));
    bus.dm_req = 1'b0;
    nxt();

    // 6. held fetch stream; the held request is ignored in its own ready cycle
    k = 0; last = 0;
    n0 = n_en;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    for (int c = 1; c <= 40 && k < 3; c++) begin
      nxt();
      if (bus.if_ready) begin
        check("t6_data", bus.if_rdata, memval(32'(4 * k)));
        if (k > 0) check("t6_gap", 32'(c - last), 32'd4);
        last = c;
        k++;
        if (k == 3) bus.if_req = 1'b0;
        else bus.if_addr = 32'(4 * k);
      end
    end
    check("t6_count", 32'(k), 32'd3);
    nxt(); nxt();
    check("t6_one_en_each", 32'(n_en - n0), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
